// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x-oversampled UART receiver (8N1 style). A 2-flop
//                synchroniser feeds a four-state FSM that samples the start
//                bit at its midpoint, shifts data bits in LSB-first, and
//                emits a one-cycle rx_done_tick or frame_err on the stop bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_tick,
    input  logic               rx,
    output logic               rx_done_tick,
    output logic [NB_DATA-1:0] dout,
    output logic               frame_err
);

    // The tick counter must reach both 15 (data bit) and SB_TICK-1 (stop bit).
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] c_MID_TICK  = S_W'(7);
    localparam logic [S_W-1:0] c_BIT_LAST  = S_W'(15);
    localparam logic [S_W-1:0] c_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] c_N_LAST    = N_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [S_W-1:0]     s_cnt_q;
    logic [N_W-1:0]     n_cnt_q;
    logic [NB_DATA-1:0] shift_q;
    logic [NB_DATA-1:0] shift_d;
    logic [NB_DATA-1:0] dout_q;
    logic               done_q;
    logic               ferr_q;
    logic [1:0]         sync_q;
    logic               rx_s;

    assign rx_s    = sync_q[1];
    // New sample enters at the MSB so the first (LSB) bit ends up at bit 0.
    assign shift_d = {rx_s, shift_q[NB_DATA-1:1]};

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Receive FSM with registered, single-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_cnt_q <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt_q == c_MID_TICK) begin
                            s_cnt_q <= '0;
                            // Still low at mid start bit: a real frame, not a glitch.
                            if (!rx_s) begin
                                state_q <= DATA;
                                n_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt_q == c_BIT_LAST) begin
                            s_cnt_q <= '0;
                            shift_q <= shift_d;
                            if (n_cnt_q == c_N_LAST) begin
                                state_q <= STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + N_W'(1);
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt_q == c_STOP_LAST) begin
                            s_cnt_q <= '0;
                            state_q <= IDLE;
                            if (rx_s) begin
                                dout_q <= shift_q;
                                done_q <= 1'b1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + S_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign dout         = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are driven on a
//                16-tick bit grid; a reference model tracks the last good
//                byte and the expected pulse counts per frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int NB_DATA = 8;
    localparam int SB_TICK = 16;

    logic               clk    = 1'b0;
    logic               reset  = 1'b1;
    logic               s_tick = 1'b0;
    logic               rx     = 1'b1;
    logic               rx_done_tick;
    logic               frame_err;
    logic [NB_DATA-1:0] dout;

    uart_rx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Tick generator: one s_tick every 4 clocks while enabled.
    bit tick_en = 1'b1;
    int div     = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (tick_en) begin
                div    = (div + 1) % 4;
                s_tick = (div == 0);
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // Output monitor: counts pulses, records received bytes, checks invariants.
    int                 done_cnt  = 0;
    int                 err_cnt   = 0;
    int                 mon_fail  = 0;
    logic [NB_DATA-1:0] rx_bytes[$];
    logic [NB_DATA-1:0] prev_dout = '0;
    bit                 prev_done = 1'b0;
    bit                 prev_err  = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                done_cnt++;
                rx_bytes.push_back(dout);
            end
            if (frame_err === 1'b1) err_cnt++;
            if (rx_done_tick === 1'b1 && frame_err === 1'b1) begin
                mon_fail++;
                if (mon_fail < 10) $display("FAIL pulse_exclusive: done=1 err=1, required at most one high");
            end
            if ((rx_done_tick === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_err)) begin
                mon_fail++;
                if (mon_fail < 10) $display("FAIL pulse_width: pulse high two cycles, required one");
            end
            if (reset === 1'b1 && dout !== prev_dout && rx_done_tick !== 1'b1) begin
                mon_fail++;
                if (mon_fail < 10) $display("FAIL dout_hold: dout %h -> %h without rx_done_tick", prev_dout, dout);
            end
            prev_dout = dout;
            prev_done = (rx_done_tick === 1'b1);
            prev_err  = (frame_err === 1'b1);
        end
    end

    // Reference model: the last byte that completed with a valid stop bit.
    logic [NB_DATA-1:0] last_good = '0;

    task automatic wait_ticks(input int n);
        int k;
        int budget;
        k      = 0;
        budget = 0;
        while (k < n) begin
            @(posedge clk);
            budget++;
            if (s_tick) k++;
            if (budget > 20000) begin
                n_fail++;
                $display("FAIL tick_wait: got %0d of %0d ticks before timeout", k, n);
                k = n;
            end
        end
    endtask

    task automatic drive_bit(input logic b, input int nt);
        @(negedge clk);
        rx = b;
        wait_ticks(nt);
    endtask

    // A bad-stop frame holds the stop bit low for 12 ticks only, so the
    // re-armed start detector sees a high line at its midpoint check.
    task automatic send_frame(input logic [NB_DATA-1:0] d, input bit stop_ok);
        drive_bit(1'b0, 16);
        for (int i = 0; i < NB_DATA; i++) drive_bit(d[i], 16);
        if (stop_ok) begin
            drive_bit(1'b1, 16);
            last_good = d;
        end else begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 4);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_tests++; if (dout !== '0)        begin n_fail++; $display("FAIL reset_dout: got %h, required 00", dout); end
        n_tests++; if (rx_done_tick !== 0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", rx_done_tick); end
        n_tests++; if (frame_err !== 0)    begin n_fail++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_frame_a5();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 4);
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t1_done: got %0d pulses, required 1", done_cnt - d0); end
        n_tests++; if (err_cnt - e0 != 0)  begin n_fail++; $display("FAIL t1_ferr: got %0d pulses, required 0", err_cnt - e0); end
        n_tests++; if (dout !== 8'hA5)     begin n_fail++; $display("FAIL t1_dout: got %h, required a5", dout); end
    endtask

    task automatic test_glitch();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        n_tests++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL t2_done: got %0d pulses, required 0", done_cnt - d0); end
        n_tests++; if (err_cnt - e0 != 0)  begin n_fail++; $display("FAIL t2_ferr: got %0d pulses, required 0", err_cnt - e0); end
        n_tests++; if (dout !== last_good) begin n_fail++; $display("FAIL t2_dout: got %h, required %h", dout, last_good); end
    endtask

    task automatic test_frame_error();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b1, 16);
        n_tests++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL t3_done: got %0d pulses, required 0", done_cnt - d0); end
        n_tests++; if (err_cnt - e0 != 1)  begin n_fail++; $display("FAIL t3_ferr: got %0d pulses, required 1", err_cnt - e0); end
        n_tests++; if (dout !== 8'hA5)     begin n_fail++; $display("FAIL t3_dout: got %h, required a5", dout); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        rx_bytes.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, 4);
        n_tests++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL t4_done: got %0d pulses, required 2", done_cnt - d0); end
        n_tests++;
        if (rx_bytes.size() != 2) begin
            n_fail++; $display("FAIL t4_bytes: got %0d bytes, required 2", rx_bytes.size());
        end else if (rx_bytes[0] !== 8'h00 || rx_bytes[1] !== 8'hFF) begin
            n_fail++; $display("FAIL t4_bytes: got %h %h, required 00 ff", rx_bytes[0], rx_bytes[1]);
        end
        n_tests++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL t4_dout: got %h, required ff", dout); end
    endtask

    task automatic test_reset_mid_frame();
        logic [NB_DATA-1:0] d;
        int d0, e0;
        d = 8'h81;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
        drive_bit(d[4], 8);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++; if (dout !== '0)        begin n_fail++; $display("FAIL t5_rst_dout: got %h, required 00", dout); end
        n_tests++; if (rx_done_tick !== 0 || frame_err !== 0) begin
            n_fail++; $display("FAIL t5_rst_pulses: got done=%b err=%b, required 0 0", rx_done_tick, frame_err);
        end
        rx = 1'b1;
        last_good = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        drive_bit(1'b1, 20);
        n_tests++; if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++; $display("FAIL t5_quiet: got %0d done %0d err after release, required 0 0", done_cnt - d0, err_cnt - e0);
        end
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 4);
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t5_done: got %0d pulses, required 1", done_cnt - d0); end
        n_tests++; if (dout !== 8'h5A)     begin n_fail++; $display("FAIL t5_dout: got %h, required 5a", dout); end
    endtask

    task automatic test_tick_gating();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_ticks(16 * 4 + 5);
                tick_en = 1'b0;
                repeat (100) @(posedge clk);
                tick_en = 1'b1;
            end
        join
        drive_bit(1'b1, 4);
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t6_done: got %0d pulses, required 1", done_cnt - d0); end
        n_tests++; if (err_cnt - e0 != 0)  begin n_fail++; $display("FAIL t6_ferr: got %0d pulses, required 0", err_cnt - e0); end
        n_tests++; if (dout !== 8'h96)     begin n_fail++; $display("FAIL t6_dout: got %h, required 96", dout); end
    endtask

    task automatic test_random_frames();
        logic [NB_DATA-1:0] d;
        bit ok;
        int d0, e0;
        for (int it = 0; it < 12; it++) begin
            d  = NB_DATA'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            d0 = done_cnt; e0 = err_cnt;
            send_frame(d, ok);
            if (ok) drive_bit(1'b1, $urandom_range(1, 6));
            else    drive_bit(1'b1, 16);
            n_tests++;
            if (done_cnt - d0 != (ok ? 1 : 0) || err_cnt - e0 != (ok ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rand_pulses[%0d]: got done=%0d err=%0d, required done=%0d err=%0d",
                         it, done_cnt - d0, err_cnt - e0, ok ? 1 : 0, ok ? 0 : 1);
            end
            n_tests++;
            if (dout !== last_good) begin
                n_fail++; $display("FAIL rand_dout[%0d]: got %h, required %h", it, dout, last_good);
            end
        end
    endtask

    task automatic test_invariants();
        n_tests++;
        if (mon_fail != 0) begin
            n_fail++; $display("FAIL invariants: got %0d violations, required 0", mon_fail);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_gating();
        test_random_frames();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
